// File: rtl/key_encoder_if.sv
// Press/release event stream from key_encoder to the voice/envelope logic.
// The master side produces events; the slave side applies backpressure.
interface key_encoder_if;
    logic [2:0] evt_num_o;
    logic       evt_press_o;
    logic       evt_val_o;
    logic       evt_rdy_i;
    logic       evt_drop_o;

    modport master (
        output evt_num_o,
        output evt_press_o,
        output evt_val_o,
        output evt_drop_o,
        input  evt_rdy_i
    );

    modport slave (
        input  evt_num_o,
        input  evt_press_o,
        input  evt_val_o,
        input  evt_drop_o,
        output evt_rdy_i
    );
endinterface

// File: rtl/key_encoder.sv
// Debounced 8-key encoder: last-note-priority note number for the key LED decoder
// plus a valid/ready stream of press/release events.
module key_encoder #(
    parameter int KEYS         = 8,
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [KEYS-1:0]   keys_i,
    output logic [2:0]        num_o,
    output logic              num_val_o,
    key_encoder_if.master     evt
);

    localparam int              CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [KEYS-1:0]  sync_p0;
    logic [KEYS-1:0]  sync_p1;
    logic [KEYS-1:0]  deb_p2;
    logic [KEYS-1:0]  deb_p3;
    logic [CNT_W-1:0] cnt [KEYS];
    logic [KEYS-1:0]  deb_edge;

    logic [KEYS-1:0]  press_c;
    logic [2:0]       last_q;
    logic             num_val_q;

    logic [KEYS-1:0]  pend;
    logic [KEYS-1:0]  ptype;
    logic             slot_free;
    logic             load;
    logic [2:0]       sel;
    logic [KEYS-1:0]  load_mask;
    logic [KEYS-1:0]  pend_live;
    logic [KEYS-1:0]  cancel;

    logic [2:0]       evt_num_q;
    logic             evt_press_q;
    logic             evt_val_q;
    logic             evt_drop_q;

    function automatic logic [2:0] lowest(input logic [KEYS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Stage p0/p1: two-flop synchroniser; stage p2: per-key debounce
    always_comb begin
        deb_edge = '0;
        for (int k = 0; k < KEYS; k++) begin
            deb_edge[k] = (sync_p1[k] != deb_p2[k]) && (cnt[k] == CNT_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb_p2  <= '0;
            for (int k = 0; k < KEYS; k++) cnt[k] <= '0;
        end else begin
            sync_p0 <= keys_i;
            sync_p1 <= sync_p0;
            for (int k = 0; k < KEYS; k++) begin
                if (sync_p1[k] == deb_p2[k]) begin
                    cnt[k] <= '0;
                end else if (deb_edge[k]) begin
                    deb_p2[k] <= sync_p1[k];
                    cnt[k]    <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    // Stage p3: last-note priority, one cycle behind the debounced state
    assign press_c = deb_p2 & ~deb_p3;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            deb_p3    <= '0;
            last_q    <= 3'd0;
            num_val_q <= 1'b0;
        end else begin
            deb_p3    <= deb_p2;
            num_val_q <= |deb_p2;
            if (|press_c) begin
                last_q <= lowest(press_c);
            end else if (!deb_p2[last_q] && (|deb_p2)) begin
                last_q <= lowest(deb_p2);
            end
        end
    end

    assign num_val_o = num_val_q;
    assign num_o     = num_val_q ? last_q : 3'd0;

    // Event path: pending flags are set alongside the debounce update, drained lowest-first
    always_comb begin
        slot_free = !evt_val_q || evt.evt_rdy_i;
        load      = slot_free && (|pend);
        sel       = lowest(pend);
        load_mask = load ? (KEYS'(1) << sel) : '0;
        // A flag being loaded this cycle is already gone, so a fresh edge re-arms it
        pend_live = pend & ~load_mask;
        cancel    = deb_edge & pend_live & (ptype ^ sync_p1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pend        <= '0;
            ptype       <= '0;
            evt_num_q   <= 3'd0;
            evt_press_q <= 1'b0;
            evt_val_q   <= 1'b0;
            evt_drop_q  <= 1'b0;
        end else begin
            if (load) begin
                evt_val_q   <= 1'b1;
                evt_num_q   <= sel;
                evt_press_q <= ptype[sel];
            end else if (slot_free) begin
                evt_val_q <= 1'b0;
            end
            evt_drop_q <= |cancel;
            for (int k = 0; k < KEYS; k++) begin
                if (deb_edge[k]) begin
                    if (cancel[k]) begin
                        pend[k] <= 1'b0;
                    end else if (!pend_live[k]) begin
                        pend[k]  <= 1'b1;
                        ptype[k] <= sync_p1[k];
                    end
                end else if (load_mask[k]) begin
                    pend[k] <= 1'b0;
                end
            end
        end
    end

    assign evt.evt_num_o   = evt_num_q;
    assign evt.evt_press_o = evt_press_q;
    assign evt.evt_val_o   = evt_val_q;
    assign evt.evt_drop_o  = evt_drop_q;

endmodule

// File: doc/key_encoder.md
Name: key_encoder

Overview:
- Converts the synth's 8 raw note keys into a 3-bit note number plus valid, the inverse of the one-hot note decoder that drives the key LEDs.
- num_o/num_val_o connect directly to the decoder's num_i/num_val_i to light the active key.
- Also emits a valid/ready stream of press/release events for the voice/envelope logic.
- Sits between the board key pins and the synth core.

Parameters:
- KEYS, 8, number of key inputs; fixed at 8 so note numbers are 3 bits.
- DEBOUNCE_CYC, 1000, consecutive stable cycles required before a key state change is accepted; minimum 1.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  synchronous active-low reset.
- keys_i  input  8  raw asynchronous key levels, 1 = pressed.
- num_o  output  3  active note number.
- num_val_o  output  1  1 = at least one debounced key held.
- evt_num_o  output  3  event note number.
- evt_press_o  output  1  event type: 1 = press, 0 = release.
- evt_val_o  output  1  event valid.
- evt_rdy_i  input  1  consumer ready.
- evt_drop_o  output  1  one-cycle pulse when a pending event pair is cancelled.

Behaviour:
- Reset, sampled on clk_i rising edge while rst_n_i = 0: clears all synchronisers, debounced states, counters, pending flags and last-pressed register. All outputs go to 0.
- Keys held through reset are treated as new: each produces a press event after normal debounce.
- Synchronisation: 2-flop synchroniser per key; the second stage is sync[k].
- Debounce, per key, with counter cnt[k] and state deb[k]:
  - If sync[k] == deb[k]: cnt[k] <= 0.
  - Otherwise cnt[k] increments.
  - When sync[k] != deb[k] and cnt[k] == DEBOUNCE_CYC-1: deb[k] <= sync[k] and cnt[k] <= 0.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes deb[k].
- Note selection, last-note priority, registered one cycle after deb:
  - On a press edge of deb[k], last <= k.
  - If several presses occur in the same cycle, the lowest index wins.
  - If deb[last] is released while other keys are held, last <= lowest-index held key.
  - num_val_o = |deb (registered). num_o = last while num_val_o = 1; num_o = 0 while num_val_o = 0.
- Latency: a clean keys_i change reaches num_val_o/num_o DEBOUNCE_CYC+3 cycles after it is first sampled.
- Event generation:
  - Each deb[k] edge sets pend[k] = 1 with ptype[k] = new deb[k], in the same cycle deb[k] updates.
  - If pend[k] is already set with the opposite type, pend[k] is cleared instead (the press/release pair cancels) and evt_drop_o pulses.
  - If pend[k] is set with the same type, the state is unchanged. This case is not reachable with debounce.
- Event arbitration:
  - The output slot is free when evt_val_o = 0, or when evt_val_o = 1 and evt_rdy_i = 1.
  - When free and any pend[k] is set, load the lowest-index pending key into evt_num_o/evt_press_o, set evt_val_o = 1, and clear that pend[k] in the same cycle.
  - This gives one cycle of latency from pend set to evt_val_o.
  - A new edge on key k in the same cycle its pend[k] is loaded sets pend[k] afresh; set takes priority over clear.
- Handshake rules:
  - Transfer occurs when evt_val_o && evt_rdy_i.
  - evt_num_o/evt_press_o are stable while evt_val_o = 1 and evt_rdy_i = 0.
  - Back-to-back transfers run at 1 per cycle.
  - With no pending work after a transfer, evt_val_o returns to 0.
  - evt_rdy_i is ignored while evt_val_o = 0.
- Backpressure never stalls debounce or num_o. Pending storage is one flag per key, so no further events are lost beyond pair cancellation.

Test Plan (DEBOUNCE_CYC = 4 unless noted):
- Reset held 3 cycles with keys_i = 8'h00, then release: all outputs 0. No event appears over 20 cycles.
- Clean press of keys_i[5] with evt_rdy_i = 1:
  - num_val_o = 1 and num_o = 5 exactly 7 cycles after the edge.
  - One event {5, press} with evt_val_o high for 1 cycle.
  - On release, num_val_o = 0, num_o = 0, and event {5, release}.
- Bounce: keys_i[2] toggled high for 3 cycles, low 1, high steady:
  - No deb change during the bounce.
  - Exactly one press event; num_o = 2 four cycles after the last toggle plus sync/reg latency.
- Last-note priority:
  - Press 1, then 6, then release 6: num_o goes 1 → 6 → 1.
  - Press 3 and 0 in the same sample cycle: num_o = 0. Events come out in order {0, press}, {3, press}.
- Backpressure:
  - evt_rdy_i = 0 while keys 4 and 7 are pressed: evt_val_o holds {4, press} stable.
  - Then rdy = 1: {4, press} and {7, press} transfer on consecutive cycles, then evt_val_o = 0.
- Cancellation and reset mid-operation:
  - With rdy = 0 and slot holding key 0, press then release key 3: evt_drop_o pulses once and no key-3 event is ever emitted.
  - Assert rst_n_i while key 5 is held: outputs clear next cycle. After release of reset, {5, press} is emitted after debounce.
